// File: rtl/freeze_bank_if.sv
// Bus bundle for freeze_bank: strobe/mask/sample inputs plus the snapshot handshake.
// The snap_ts signal exists only when FREEZE_SNAP_TS_EN is defined.
interface freeze_bank_if #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2
) ();
  logic                      s;
  logic [CHANNELS-1:0]       freeze_mask;
  logic [CHANNELS*WIDTH-1:0] in;
  logic [CHANNELS*WIDTH-1:0] out;
  logic                      arm;
  logic                      trig;
  logic                      ack;
  logic [CHANNELS*WIDTH-1:0] snap;
  logic                      snap_valid;
  logic [1:0]                state;
  logic                      overrun;
`ifdef FREEZE_SNAP_TS_EN
  logic [15:0]               snap_ts;
`endif

  modport master (
    output s, freeze_mask, in, arm, trig, ack,
    input  out, snap, snap_valid, state, overrun
`ifdef FREEZE_SNAP_TS_EN
    , snap_ts
`endif
  );

  modport slave (
    input  s, freeze_mask, in, arm, trig, ack,
    output out, snap, snap_valid, state, overrun
`ifdef FREEZE_SNAP_TS_EN
    , snap_ts
`endif
  );
endinterface

// File: rtl/freeze_bank.sv
// Multi-channel strobed delay lines with per-channel freeze and a coherent snapshot engine.
// Define FREEZE_SNAP_TS_EN to add a strobe counter whose value is captured into snap_ts.
module freeze_bank #(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  freeze_bank_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } stateT;

  stateT                     stateQ;
  logic [CHANNELS*WIDTH-1:0] snapQ;
  logic                      snapValidQ;
  logic                      overrunQ;

  // Each channel owns its own pipe so frozen channels simply skip the shift.
  for (genvar c = 0; c < CHANNELS; c++) begin : gChan
    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) pipe[k] <= '0;
      end else if (bus.s && !bus.freeze_mask[c]) begin
        pipe[0] <= bus.in[c*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
      end
    end

    assign bus.out[c*WIDTH +: WIDTH] = pipe[DEPTH-1];
  end

`ifdef FREEZE_SNAP_TS_EN
  logic [15:0] tsCount;
  logic [15:0] snapTsQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tsCount <= '0;
    end else if (bus.s) begin
      tsCount <= tsCount + 16'd1;
    end
  end

  assign bus.snap_ts = snapTsQ;
`endif

  // Capture reads bus.out, which is still the pre-advance value in the trigger cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ     <= IDLE;
      snapQ      <= '0;
      snapValidQ <= 1'b0;
      overrunQ   <= 1'b0;
`ifdef FREEZE_SNAP_TS_EN
      snapTsQ    <= '0;
`endif
    end else begin
      case (stateQ)
        IDLE: begin
          if (bus.arm) begin
            stateQ   <= ARMED;
            overrunQ <= 1'b0;
          end
        end
        ARMED: begin
          if (bus.trig) begin
            stateQ     <= HOLD;
            snapQ      <= bus.out;
            snapValidQ <= 1'b1;
`ifdef FREEZE_SNAP_TS_EN
            snapTsQ    <= tsCount;
`endif
          end
        end
        HOLD: begin
          if (bus.trig) overrunQ <= 1'b1;
          if (bus.ack) begin
            stateQ     <= IDLE;
            snapValidQ <= 1'b0;
          end
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign bus.snap       = snapQ;
  assign bus.snap_valid = snapValidQ;
  assign bus.state      = stateQ;
  assign bus.overrun    = overrunQ;

endmodule
